// File: rtl/eqcmp_bist_pkg.sv
// ============================================================================
// Module      : eqcmp_bist_pkg
// Description : Shared state encoding and default sizing for the equality
//               comparator BIST.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eqcmp_bist_pkg;

    localparam int c_DEF_W    = 2;
    localparam int c_DEF_HOLD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/eqcmp_bist_hold_timer.sv
// ============================================================================
// Module      : hold_timer
// Description : Mod-HOLD counter; tc pulses on the last cycle of each hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hold_timer #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int             c_CW   = $clog2(HOLD);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(HOLD - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [c_CW-1:0] r_cnt;

    assign tc = en && (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == c_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/eqcmp_bist.sv
// ============================================================================
// Module      : eqcmp_bist
// Description : Exhaustive BIST for a W-bit equality comparator; sweeps all
//               {A,B} pairs, counts mismatches and records the first failure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eqcmp_bist
    import eqcmp_bist_pkg::*;
#(
    parameter int W    = c_DEF_W,
    parameter int HOLD = c_DEF_HOLD
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic [W-1:0]   a_out,
    output logic [W-1:0]   b_out,
    input  logic           aeqb_in,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*W:0]   err_cnt,
    output logic [2*W-1:0] first_fail
);

    localparam int               c_IW      = 2 * W;
    localparam logic [c_IW-1:0]  c_IDX_ONE = c_IW'(1);
    localparam logic [c_IW:0]    c_ERR_ONE = (c_IW + 1)'(1);

    state_t            r_state;
    state_t            w_next;
    logic [c_IW-1:0]   r_idx;
    logic [c_IW:0]     r_err_cnt;
    logic [c_IW-1:0]   r_first_fail;

    logic w_start_acc;
    logic w_tc;
    logic w_last;
    logic w_mismatch;

    assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last      = (r_idx == {c_IW{1'b1}});
    assign w_mismatch  = w_tc && (aeqb_in != (a_out == b_out));

    hold_timer #(
        .HOLD (HOLD)
    ) u_hold_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (w_start_acc),
        .en    (r_state == ST_DRIVE),
        .tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE,
            ST_DONE:  if (start) w_next = ST_DRIVE;
            ST_DRIVE: if (w_tc && w_last) w_next = ST_DONE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // idx doubles as the operand register, so a_out/b_out are glitch-free
    always_ff @(posedge clk) begin
        if (reset || w_start_acc) begin
            r_idx        <= '0;
            r_err_cnt    <= '0;
            r_first_fail <= '1;
        end else if (w_tc) begin
            if (w_mismatch) begin
                r_err_cnt <= r_err_cnt + c_ERR_ONE;
                if (r_err_cnt == '0) begin
                    r_first_fail <= r_idx;
                end
            end
            if (!w_last) begin
                r_idx <= r_idx + c_IDX_ONE;
            end
        end
    end

    assign a_out      = r_idx[c_IW-1:W];
    assign b_out      = r_idx[W-1:0];
    assign busy       = (r_state == ST_DRIVE);
    assign done       = (r_state == ST_DONE);
    assign pass       = done && (r_err_cnt == '0);
    assign err_cnt    = r_err_cnt;
    assign first_fail = r_first_fail;

endmodule

`default_nettype wire

// File: tb/tb_eqcmp_bist.sv
// ============================================================================
// Module      : tb_eqcmp_bist
// Description : Directed self-checking bench for eqcmp_bist using a modelled
//               2-bit comparator with selectable faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eqcmp_bist;

    localparam int c_MODE_OK   = 0;
    localparam int c_MODE_SA0  = 1;
    localparam int c_MODE_SA1  = 2;
    localparam int c_MODE_INV  = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] a_out;
    logic [1:0] b_out;
    logic       aeqb_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_cnt;
    logic [3:0] first_fail;

    int mode;
    int n_tests;
    int n_fail;

    eqcmp_bist #(
        .W    (2),
        .HOLD (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a_out      (a_out),
        .b_out      (b_out),
        .aeqb_in    (aeqb_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .first_fail (first_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // comparator under test, with injectable faults
    always_comb begin
        case (mode)
            c_MODE_SA0: aeqb_in = 1'b0;
            c_MODE_SA1: aeqb_in = 1'b1;
            c_MODE_INV: aeqb_in = (a_out != b_out);
            default:    aeqb_in = (a_out == b_out);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_err"},  32'(err_cnt), 32'd0);
        check({tag, "_ff"},   32'(first_fail), 32'hF);
        check({tag, "_ab"},   32'({a_out, b_out}), 32'd0);
    endtask

    // rst_at / repulse_at: edge count after accept, or -1 for none
    task automatic run(input int m, input int exp_err, input int exp_ff,
                       input logic exp_pass, input int rst_at, input int repulse_at,
                       input string tag);
        int k;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        check({tag, "_busy0"}, 32'({busy, done}), 32'b10);
        check({tag, "_clr0"},  32'({err_cnt, first_fail}), 32'h00F);
        while (!done && k < 200) begin
            if (m == c_MODE_INV && k < 64)
                check({tag, "_vec"}, 32'({a_out, b_out}), 32'(k / 4));
            if (k == repulse_at)     start = 1'b1;
            if (k == repulse_at + 1) start = 1'b0;
            if (k == rst_at - 1)     reset = 1'b1;
            @(posedge clk);
            #1;
            k++;
            if (k == rst_at) begin
                reset = 1'b0;
                check_reset_outputs({tag, "_abort"});
                return;
            end
        end
        check({tag, "_edges"}, 32'(k), 32'd64);
        check({tag, "_err"},   32'(err_cnt), 32'(exp_err));
        check({tag, "_ff"},    32'(first_fail), 32'(exp_ff));
        check({tag, "_pass"},  32'(pass), 32'(exp_pass));
        check({tag, "_busy"},  32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_hold"}, 32'({done, pass, err_cnt, first_fail}),
              32'({1'b1, exp_pass, 5'(exp_err), 4'(exp_ff)}));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mode    = c_MODE_OK;
        reset   = 1'b1;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("idle");

        run(c_MODE_OK,  0,  4'b1111, 1'b1, -1, -1, "ok");
        run(c_MODE_SA0, 4,  4'b0000, 1'b0, -1, -1, "sa0");
        run(c_MODE_SA1, 12, 4'b0001, 1'b0, -1, -1, "sa1");
        run(c_MODE_INV, 16, 4'b0000, 1'b0, -1, -1, "inv");
        run(c_MODE_INV, 0,  0,       1'b0, 30, -1, "rstmid");
        run(c_MODE_SA1, 12, 4'b0001, 1'b0, -1, -1, "after_rst");
        run(c_MODE_SA0, 4,  4'b0000, 1'b0, -1, 20, "repulse");
        run(c_MODE_OK,  0,  4'b1111, 1'b1, -1, -1, "restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/eqcmp_bist.md
EQCMP_BIST -- requirements
Module: eqcmp_bist

Interface
REQ-001 Parameter W, default 2, SHALL set the operand width of the comparator under test.
REQ-002 Parameter HOLD, default 4, SHALL set the clock cycles each vector is held; legal range 2..255.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL request a test run, sampled only in IDLE or DONE.
REQ-006 a_out  output  W  SHALL be the operand A driven to the comparator.
REQ-007 b_out  output  W  SHALL be the operand B driven to the comparator.
REQ-008 aeqb_in  input  1  SHALL be the comparator's equality result.
REQ-009 busy  output  1  SHALL be high while vectors are being applied.
REQ-010 done  output  1  SHALL be high when a run has completed.
REQ-011 pass  output  1  SHALL be high when done is high and err_cnt is 0.
REQ-012 err_cnt  output  2W+1  SHALL be the mismatch count of the current or last run.
REQ-013 first_fail  output  2W  SHALL be the vector index {A,B} of the first mismatch.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, DONE.
REQ-015 Vector index idx (2W bits) SHALL map as a_out = idx[2W-1:W], b_out = idx[W-1:0]; A is the outer loop, B the inner loop.
REQ-016 IDLE or DONE with start=1 SHALL go to DRIVE at the next edge, clearing idx, hold counter, err_cnt and first_fail.
REQ-017 In DRIVE, each vector SHALL be held exactly HOLD cycles; a_out/b_out SHALL be registered and stable throughout.
REQ-018 On the edge ending the HOLD-th cycle, aeqb_in SHALL be compared with (a_out == b_out); on mismatch, err_cnt SHALL increment by 1.
REQ-019 On the first mismatch of a run, first_fail SHALL capture idx; later mismatches SHALL leave it unchanged.
REQ-020 After the compare edge, idx SHALL increment; for idx = 2^(2W)-1 the FSM SHALL instead go to DONE and idx SHALL stay at its last value.
REQ-021 done SHALL rise exactly 2^(2W)*HOLD edges after the edge that accepted start (64 for defaults).
REQ-022 DONE SHALL persist, with err_cnt/first_fail/pass stable, until reset or a new start.
REQ-023 start during DRIVE SHALL be ignored.
REQ-024 busy SHALL be 1 only in DRIVE; done SHALL be 1 only in DONE; busy and done SHALL never be high together.
REQ-025 err_cnt SHALL not wrap; its width holds the maximum 2^(2W).
REQ-026 first_fail SHALL be all-ones when err_cnt is 0 and SHALL be ignored by users unless err_cnt is non-zero.

Reset
REQ-027 reset SHALL force IDLE, idx=0, hold counter=0, a_out=0, b_out=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=all-ones.
REQ-028 reset asserted mid-run SHALL abort the run at the next edge with no partial results retained; reset SHALL take priority over start.

Structure
REQ-029 Package eqcmp_bist_pkg SHALL hold the state enum typedef and default constants for W and HOLD.
REQ-030 The per-vector hold count SHALL be a separate sub-module, hold_timer (mod-HOLD counter with a terminal-count pulse); the FSM, idx, and error logic SHALL stay in eqcmp_bist.

Verification
REQ-031 Correct 2-bit comparator, HOLD=4, start pulse -> done after 64 edges, pass=1, err_cnt=0, first_fail=4'b1111.
REQ-032 Comparator stuck at 0 -> err_cnt=4, first_fail=4'b0000, pass=0.
REQ-033 Comparator stuck at 1 -> err_cnt=12, first_fail=4'b0001.
REQ-034 Inverted comparator -> err_cnt=16, first_fail=4'b0000; a_out/b_out traverse 00/00, 00/01 ... 11/11, each held 4 cycles.
REQ-035 reset at edge 30 of a run -> all outputs at reset values next cycle; a subsequent start gives a full 64-edge run with correct results.
REQ-036 start re-pulsed during DRIVE -> no effect on timing; start re-pulsed in DONE -> clean restart with counters cleared.
